// File: rtl/cv32e40s_idx_to_vec.sv
// cv32e40s_idx_to_vec: turns binary set/clear index requests into a registered pending vector
// with an incrementally maintained set-bit count, full/empty flags and an error pulse.
module cv32e40s_idx_to_vec #(
   parameter int LEN      = 32,
   parameter bit SET_WINS = 1'b1,
   localparam int IDX_W   = (LEN > 1) ? $clog2(LEN) : 1,
   localparam int CNT_W   = $clog2(LEN + 1)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             set_valid_i,
   input  logic [IDX_W-1:0] set_idx_i,
   input  logic             clr_valid_i,
   input  logic [IDX_W-1:0] clr_idx_i,
   input  logic             clr_all_i,
   output logic [LEN-1:0]   vec_o,
   output logic [LEN-1:0]   onehot_o,
   output logic [CNT_W-1:0] count_o,
   output logic             empty_o,
   output logic             full_o,
   output logic             err_o
);
   localparam logic [IDX_W:0] LEN_C = (IDX_W + 1)'(LEN);

   logic [LEN-1:0]   vec_q, vec_d, onehot_q, onehot_d;
   logic [CNT_W-1:0] count_q, count_d;
   logic             err_q, err_d;
   logic             set_in, clr_in, set_ok, clr_ok, same, dup;
   logic [LEN-1:0]   set_mask, clr_mask, eff_set, eff_clr, new_set, new_clr;

   always_comb begin
      set_in   = {1'b0, set_idx_i} < LEN_C;
      clr_in   = {1'b0, clr_idx_i} < LEN_C;
      set_ok   = set_valid_i & set_in;
      clr_ok   = clr_valid_i & clr_in;
      set_mask = set_ok ? (LEN'(1) << set_idx_i) : '0;
      clr_mask = clr_ok ? (LEN'(1) << clr_idx_i) : '0;
      same     = set_ok & clr_ok & (set_idx_i == clr_idx_i);
      // A same-index collision resolves to a single effective operation chosen by SET_WINS
      eff_set  = (same && !SET_WINS) ? '0 : set_mask;
      eff_clr  = (same && SET_WINS) ? '0 : clr_mask;
      new_set  = eff_set & ~vec_q;
      new_clr  = eff_clr & vec_q;
      dup      = |(set_mask & vec_q) & ~same;
      vec_d    = clr_all_i ? '0 : (vec_q | new_set) & ~new_clr;
      onehot_d = clr_all_i ? '0 : (|new_set) ? new_set : onehot_q;
      count_d  = clr_all_i ? '0 : count_q + CNT_W'(|new_set) - CNT_W'(|new_clr);
      err_d    = ~clr_all_i & ((set_valid_i & ~set_in) | (clr_valid_i & ~clr_in) | dup);
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         vec_q    <= '0;
         onehot_q <= '0;
         count_q  <= '0;
         err_q    <= 1'b0;
      end else begin
         vec_q    <= vec_d;
         onehot_q <= onehot_d;
         count_q  <= count_d;
         err_q    <= err_d;
      end
   end

   assign vec_o    = vec_q;
   assign onehot_o = onehot_q;
   assign count_o  = count_q;
   assign empty_o  = count_q == '0;
   assign full_o   = count_q == CNT_W'(LEN);
   assign err_o    = err_q;
endmodule

// File: tb/tb_cv32e40s_idx_to_vec.sv
// tb_cv32e40s_idx_to_vec: directed checks on LEN=32 (both SET_WINS settings) and LEN=5 builds,
// followed by a randomized run against a behavioural model.
module tb_cv32e40s_idx_to_vec;
   logic clk = 1'b0, rst_n = 1'b0;
   logic sv = 0, cv = 0, ca = 0;
   logic [4:0] si = 0, ci = 0;
   logic [31:0] v_a, oh_a, v_b, oh_b;
   logic [5:0] cnt_a, cnt_b;
   logic e_a, f_a, er_a, e_b, f_b, er_b;
   logic s5v = 0, c5v = 0, c5a = 0;
   logic [2:0] s5i = 0, c5i = 0;
   logic [4:0] v5, oh5;
   logic [2:0] cnt5;
   logic e5, f5, er5;
   int nvec = 0, nerr = 0;

   always #5 clk = ~clk;

   cv32e40s_idx_to_vec #(.LEN(32), .SET_WINS(1'b1)) u_a (
      .clk(clk), .rst_n(rst_n), .set_valid_i(sv), .set_idx_i(si), .clr_valid_i(cv), .clr_idx_i(ci),
      .clr_all_i(ca), .vec_o(v_a), .onehot_o(oh_a), .count_o(cnt_a), .empty_o(e_a), .full_o(f_a), .err_o(er_a));
   cv32e40s_idx_to_vec #(.LEN(32), .SET_WINS(1'b0)) u_b (
      .clk(clk), .rst_n(rst_n), .set_valid_i(sv), .set_idx_i(si), .clr_valid_i(cv), .clr_idx_i(ci),
      .clr_all_i(ca), .vec_o(v_b), .onehot_o(oh_b), .count_o(cnt_b), .empty_o(e_b), .full_o(f_b), .err_o(er_b));
   cv32e40s_idx_to_vec #(.LEN(5), .SET_WINS(1'b1)) u_5 (
      .clk(clk), .rst_n(rst_n), .set_valid_i(s5v), .set_idx_i(s5i), .clr_valid_i(c5v), .clr_idx_i(c5i),
      .clr_all_i(c5a), .vec_o(v5), .onehot_o(oh5), .count_o(cnt5), .empty_o(e5), .full_o(f5), .err_o(er5));

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      nvec++;
      assert (obs === exp) else begin
         nerr++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic req(input logic s, input logic [4:0] sidx, input logic c, input logic [4:0] cidx, input logic all);
      sv = s; si = sidx; cv = c; ci = cidx; ca = all;
      step();
      sv = 0; cv = 0; ca = 0;
   endtask

   logic [31:0] mv, moh;
   int mc;
   logic me;

   initial begin
      // reset held for two clocks while a set request is present
      rst_n = 0; sv = 1; si = 7;
      step(); step();
      chk("rst_vec", v_a, 0);
      chk("rst_cnt", cnt_a, 0);
      chk("rst_empty", e_a, 1);
      chk("rst_full", f_a, 0);
      chk("rst_err", er_a, 0);
      chk("rst_onehot", oh_a, 0);
      chk("rst_vec5", v5, 0);
      sv = 0; rst_n = 1;
      step();
      chk("idle_vec", v_a, 0);

      req(1, 5, 0, 0, 0);
      chk("set5_vec", v_a, 32'h20);
      chk("set5_cnt", cnt_a, 1);
      chk("set5_oh", oh_a, 32'h20);
      chk("set5_err", er_a, 0);
      chk("set5_empty", e_a, 0);
      req(1, 31, 0, 0, 0);
      chk("set31_vec", v_a, 32'h8000_0020);
      chk("set31_cnt", cnt_a, 2);
      chk("set31_oh", oh_a, 32'h8000_0000);
      chk("set31_err", er_a, 0);
      req(1, 5, 0, 0, 0);
      chk("dup_vec", v_a, 32'h8000_0020);
      chk("dup_cnt", cnt_a, 2);
      chk("dup_err", er_a, 1);
      chk("dup_oh", oh_a, 32'h8000_0000);
      step();
      chk("dup_err_pulse", er_a, 0);
      req(0, 0, 1, 5, 0);
      chk("clr5_vec", v_a, 32'h8000_0000);
      chk("clr5_cnt", cnt_a, 1);
      req(0, 0, 1, 5, 0);
      chk("clr_clear_vec", v_a, 32'h8000_0000);
      chk("clr_clear_err", er_a, 0);
      req(0, 0, 0, 0, 1);
      chk("clrall_vec", v_a, 0);
      chk("clrall_oh", oh_a, 0);
      chk("clrall_cnt", cnt_a, 0);

      // same-index set+clear on a clear bit
      req(1, 3, 1, 3, 0);
      chk("same_sw1_vec", v_a, 32'h8);
      chk("same_sw1_cnt", cnt_a, 1);
      chk("same_sw1_oh", oh_a, 32'h8);
      chk("same_sw1_err", er_a, 0);
      chk("same_sw0_vec", v_b, 0);
      chk("same_sw0_cnt", cnt_b, 0);
      chk("same_sw0_err", er_b, 0);
      req(1, 3, 0, 0, 0);
      chk("sw1_dup_err", er_a, 1);
      chk("sw0_set_vec", v_b, 32'h8);
      chk("sw0_set_err", er_b, 0);
      // same-index set+clear on a set bit
      req(1, 3, 1, 3, 0);
      chk("same_set_sw1_vec", v_a, 32'h8);
      chk("same_set_sw1_err", er_a, 0);
      chk("same_set_sw1_cnt", cnt_a, 1);
      chk("same_set_sw0_vec", v_b, 0);
      chk("same_set_sw0_cnt", cnt_b, 0);
      chk("same_set_sw0_oh", oh_b, 32'h8);
      // set and clear at different indices: net zero
      req(1, 1, 1, 3, 0);
      chk("diff_vec", v_a, 32'h2);
      chk("diff_cnt", cnt_a, 1);
      chk("diff_oh", oh_a, 32'h2);
      req(0, 0, 0, 0, 1);

      for (int i = 0; i < 32; i++) req(1, 5'(i), 0, 0, 0);
      chk("fill_vec", v_a, 32'hFFFF_FFFF);
      chk("fill_cnt", cnt_a, 32);
      chk("fill_full", f_a, 1);
      chk("fill_empty", e_a, 0);
      chk("fill_oh", oh_a, 32'h8000_0000);
      chk("fill_full_b", f_b, 1);
      req(1, 0, 0, 0, 1);
      chk("clrall_set_vec", v_a, 0);
      chk("clrall_set_cnt", cnt_a, 0);
      chk("clrall_set_err", er_a, 0);
      chk("clrall_set_empty", e_a, 1);
      chk("clrall_set_full", f_a, 0);

      // LEN=5 out-of-range handling
      s5v = 1; s5i = 6; step(); s5v = 0;
      chk("l5_oor_vec", v5, 0);
      chk("l5_oor_err", er5, 1);
      chk("l5_oor_cnt", cnt5, 0);
      step();
      chk("l5_err_pulse", er5, 0);
      c5v = 1; c5i = 2; step(); c5v = 0;
      chk("l5_clr_clear_vec", v5, 0);
      chk("l5_clr_clear_err", er5, 0);
      s5v = 1; s5i = 4; step(); s5v = 0;
      chk("l5_set4_vec", v5, 5'h10);
      chk("l5_set4_oh", oh5, 5'h10);
      c5v = 1; c5i = 5; step(); c5v = 0;
      chk("l5_clr_oor_err", er5, 1);
      chk("l5_clr_oor_vec", v5, 5'h10);
      for (int i = 0; i < 4; i++) begin s5v = 1; s5i = 3'(i); step(); end
      s5v = 0;
      chk("l5_full", f5, 1);
      chk("l5_cnt", cnt5, 5);

      // randomized run against a model of the SET_WINS=1 instance
      rst_n = 0; step(); rst_n = 1;
      mv = 0; moh = 0; mc = 0; me = 0;
      for (int n = 0; n < 400; n++) begin
         sv = 1'($urandom_range(0, 1));
         cv = 1'($urandom_range(0, 1));
         si = 5'($urandom);
         ci = ($urandom_range(0, 3) == 0) ? si : 5'($urandom);
         ca = ($urandom_range(0, 24) == 0);
         rst_n = ($urandom_range(0, 39) != 0);
         me = 0;
         if (!rst_n || ca) begin
            mv = 0; moh = 0; mc = 0;
         end else if (sv && cv && si == ci) begin
            if (!mv[si]) begin mv[si] = 1; mc++; moh = 32'h1 << si; end
         end else begin
            if (sv) begin
               if (mv[si]) me = 1;
               else begin mv[si] = 1; mc++; moh = 32'h1 << si; end
            end
            if (cv && mv[ci]) begin mv[ci] = 0; mc--; end
         end
         step();
         chk("rnd_vec", v_a, mv);
         chk("rnd_cnt", cnt_a, 64'(mc));
         chk("rnd_pop", cnt_a, 64'($countones(v_a)));
         chk("rnd_oh", oh_a, moh);
         chk("rnd_err", er_a, me);
         chk("rnd_full", f_a, mc == 32);
         chk("rnd_empty", e_a, mc == 0);
      end
      sv = 0; cv = 0; ca = 0; rst_n = 1;
      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end
endmodule
